softusb_tx_serializer: RTL and testbench

Full/low-speed USB transmit serializer. It is the bit-level consumer of the SIE byte handshake (tx_data/tx_valid/tx_ready).
- Emits SYNC, then LSB-first data bytes with bit stuffing and NRZI, then EOP.
- Drives the differential transceiver pins at 48 MHz usb_clk.
- Also emits a standalone EOP on request (low-speed keep-alive).

---
 rtl/softusb_tx_pkg.sv | 31 +++
 rtl/softusb_tx_if.sv | 24 ++
 rtl/softusb_tx_stuffer.sv | 47 ++++
 rtl/softusb_tx_serializer.sv | 199 +++++++++++++++++++
 tb/tb_softusb_tx_serializer.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/softusb_tx_pkg.sv
// softusb_tx_pkg: shared types and constants for the USB transmit serializer.
// Line codes are full-speed polarity; line_pins() swaps J/K for low speed.
package softusb_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_EOP_SE0,
    S_EOP_J
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam int STUFF_LIMIT = 6;

  // {txp, txm} at full speed
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  function automatic logic [1:0] line_pins(
    input logic [1:0] code,
    input logic       ls
  );
    if (ls && code != LINE_SE0) begin
      return {code[0], code[1]};
    end
    return code;
  endfunction

endpackage

// File: rtl/softusb_tx_if.sv
// softusb_tx_if: SIE byte handshake between packet engine and serializer.
// master = byte producer (SIE), slave = serializer.
interface softusb_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_busy
  );

endinterface

// File: rtl/softusb_tx_stuffer.sv
// softusb_tx_stuffer: bit stuffing and NRZI for one transmitted bit per strobe.
// clr_i restarts the NRZI reference at J with an empty ones counter.
module softusb_tx_stuffer
  import softusb_tx_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       strobe_i,
  input  logic       bit_i,
  output logic       stall_o,
  output logic [1:0] line_o
);

  logic       k_q;
  logic       k_d;
  logic       k_base;
  logic       toggle;
  logic [2:0] ones_q;
  logic [2:0] ones_d;
  logic [2:0] ones_base;

  // clr_i and strobe_i together: first bit is coded from a fresh reference
  always_comb begin
    k_base    = clr_i ? 1'b0 : k_q;
    ones_base = clr_i ? 3'd0 : ones_q;
    stall_o   = (ones_base == 3'(STUFF_LIMIT));
    toggle    = stall_o | ~bit_i;
    k_d       = k_base ^ toggle;
    ones_d    = toggle ? 3'd0 : ones_base + 3'd1;
    line_o    = k_d ? LINE_K : LINE_J;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q    <= 1'b0;
      ones_q <= 3'd0;
    end else if (strobe_i) begin
      k_q    <= k_d;
      ones_q <= ones_d;
    end else if (clr_i) begin
      k_q    <= 1'b0;
      ones_q <= 3'd0;
    end
  end

endmodule

// File: rtl/softusb_tx_serializer.sv
// softusb_tx_serializer: FS/LS USB transmitter (SYNC, stuffed NRZI data, EOP).
// Optional SOFTUSB_TX_STUFFCNT_EN adds a saturating stuff_count output.
module softusb_tx_serializer
  import softusb_tx_pkg::*;
#(
  parameter int FS_DIV = 4,
  parameter int LS_DIV = 32
)
(
  input  logic        usb_clk,
  input  logic        usb_rst,
  softusb_tx_if.slave sie,
  input  logic        low_speed,
  input  logic        generate_eop,
  output logic        txp,
  output logic        txm,
  output logic        txoe
`ifdef SOFTUSB_TX_STUFFCNT_EN
  ,
  output logic [15:0] stuff_count
`endif
);

  localparam int MAX_DIV = (LS_DIV > FS_DIV) ? LS_DIV : FS_DIV;
  localparam int CNT_W   = $clog2(MAX_DIV);

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t bit_div(input logic ls);
    return ls ? cnt_t'(LS_DIV - 1) : cnt_t'(FS_DIV - 1);
  endfunction

  state_e     state_q;
  cnt_t       cnt_q;
  logic [2:0] idx_q;
  logic [6:0] shift_q;
  logic       ls_q;
  logic [1:0] pins_q;
  logic       txoe_q;
  logic       ready_q;
  logic       busy_q;

  logic       bit_end;
  logic       clr;
  logic       strobe;
  logic       sbit;
  logic       stall;
  logic [1:0] nxt_line;

  assign bit_end = (cnt_q == '0);
  assign clr     = (state_q == S_IDLE);

  softusb_tx_stuffer u_stuff (
    .clk_i    (usb_clk),
    .rst_i    (usb_rst),
    .clr_i    (clr),
    .strobe_i (strobe),
    .bit_i    (sbit),
    .stall_o  (stall),
    .line_o   (nxt_line)
  );

  // shift_q holds bits 7:1 of the byte; bit 0 goes out on the load edge
  always_comb begin
    strobe = 1'b0;
    sbit   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!generate_eop && sie.tx_valid) begin
          strobe = 1'b1;
          sbit   = SYNC_BYTE[0];
        end
      end
      S_SYNC, S_DATA: begin
        if (bit_end) begin
          if (stall) begin
            strobe = 1'b1;
          end else if (idx_q != 3'd7) begin
            strobe = 1'b1;
            sbit   = shift_q[idx_q];
          end else if (sie.tx_valid) begin
            strobe = 1'b1;
            sbit   = sie.tx_data[0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ls_q    <= 1'b0;
      pins_q  <= LINE_J;
      txoe_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          pins_q <= line_pins(LINE_J, low_speed);
          if (generate_eop) begin
            state_q <= S_EOP_SE0;
            ls_q    <= low_speed;
            cnt_q   <= bit_div(low_speed);
            idx_q   <= '0;
            pins_q  <= LINE_SE0;
            txoe_q  <= 1'b1;
            busy_q  <= 1'b1;
          end else if (sie.tx_valid) begin
            state_q <= S_SYNC;
            ls_q    <= low_speed;
            cnt_q   <= bit_div(low_speed);
            idx_q   <= '0;
            shift_q <= SYNC_BYTE[7:1];
            pins_q  <= line_pins(nxt_line, low_speed);
            txoe_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_SYNC, S_DATA: begin
          if (!bit_end) begin
            cnt_q <= cnt_q - cnt_t'(1);
          end else begin
            cnt_q <= bit_div(ls_q);
            if (stall) begin
              pins_q <= line_pins(nxt_line, ls_q);
            end else if (idx_q != 3'd7) begin
              idx_q  <= idx_q + 3'd1;
              pins_q <= line_pins(nxt_line, ls_q);
            end else if (sie.tx_valid) begin
              state_q <= S_DATA;
              shift_q <= sie.tx_data[7:1];
              idx_q   <= '0;
              ready_q <= 1'b1;
              pins_q  <= line_pins(nxt_line, ls_q);
            end else begin
              state_q <= S_EOP_SE0;
              idx_q   <= '0;
              pins_q  <= LINE_SE0;
            end
          end
        end
        S_EOP_SE0: begin
          if (!bit_end) begin
            cnt_q <= cnt_q - cnt_t'(1);
          end else begin
            cnt_q <= bit_div(ls_q);
            if (idx_q == 3'd0) begin
              idx_q <= 3'd1;
            end else begin
              state_q <= S_EOP_J;
              pins_q  <= line_pins(LINE_J, ls_q);
            end
          end
        end
        S_EOP_J: begin
          if (!bit_end) begin
            cnt_q <= cnt_q - cnt_t'(1);
          end else begin
            state_q <= S_IDLE;
            txoe_q  <= 1'b0;
            busy_q  <= 1'b0;
            pins_q  <= line_pins(LINE_J, low_speed);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SOFTUSB_TX_STUFFCNT_EN
  logic [15:0] stuff_cnt_q;

  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      stuff_cnt_q <= '0;
    end else if (strobe && stall && stuff_cnt_q != 16'hFFFF) begin
      stuff_cnt_q <= stuff_cnt_q + 16'd1;
    end
  end

  assign stuff_count = stuff_cnt_q;
`endif

  assign sie.tx_ready = ready_q;
  assign sie.tx_busy  = busy_q;
  assign txp          = pins_q[1];
  assign txm          = pins_q[0];
  assign txoe         = txoe_q;

endmodule

// File: tb/tb_softusb_tx_serializer.sv
// tb_softusb_tx_serializer: directed packet vectors plus EOP/reset sequences.
// Line symbols: J, K, 0 (SE0), sampled mid-bit.
module tb_softusb_tx_serializer;

  logic clk;
  logic usb_rst;
  logic low_speed;
  logic generate_eop;
  logic txp;
  logic txm;
  logic txoe;
`ifdef SOFTUSB_TX_STUFFCNT_EN
  logic [15:0] stuff_count;
`endif

  softusb_tx_if sif ();

  softusb_tx_serializer dut (
    .usb_clk      (clk),
    .usb_rst      (usb_rst),
    .sie          (sif.slave),
    .low_speed    (low_speed),
    .generate_eop (generate_eop),
    .txp          (txp),
    .txm          (txm),
    .txoe         (txoe)
`ifdef SOFTUSB_TX_STUFFCNT_EN
    ,
    .stuff_count  (stuff_count)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string      name;
    logic       ls;
    int         n;
    logic [7:0] d0;
    logic [7:0] d1;
    string      line;
    int         stuffs;
  } vec_t;

  vec_t vecs[4];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input bit ok, input string name,
                       input string act, input string exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  function automatic string sym(input logic [1:0] pm, input logic ls);
    if (pm == 2'b00) return "0";
    if (pm == (ls ? 2'b01 : 2'b10)) return "J";
    if (pm == (ls ? 2'b10 : 2'b01)) return "K";
    return "X";
  endfunction

  function automatic string d2s(input int v);
    return $sformatf("%0d", v);
  endfunction

  task automatic run_packet(input vec_t v);
    logic [7:0] bytes[2];
    logic [1:0] q[$];
    int k, rdy, bmis, cyc, misal, div;
    bit seen, first_ok;
    string s;
`ifdef SOFTUSB_TX_STUFFCNT_EN
    int sc0;
    sc0 = int'(stuff_count);
`endif
    bytes[0] = v.d0;
    bytes[1] = v.d1;
    div = v.ls ? 32 : 4;
    low_speed = v.ls;
    sif.tx_data = bytes[0];
    sif.tx_valid = 1'b1;
    k = 0; rdy = 0; bmis = 0; cyc = 0; seen = 0; first_ok = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) first_ok = txoe && sym({txp, txm}, v.ls) == "K";
      if (sif.tx_busy !== txoe) bmis++;
      if (sif.tx_ready) begin
        rdy++;
        k++;
        if (k < v.n) sif.tx_data = bytes[k];
        else sif.tx_valid = 1'b0;
      end
      if (txoe) begin
        seen = 1;
        q.push_back({txp, txm});
      end else if (seen) begin
        break;
      end
    end
    sif.tx_valid = 1'b0;
    check(seen && !txoe, {v.name, " done"}, d2s(cyc), "<2000 cycles");
    check(first_ok, {v.name, " latency"}, d2s(int'(first_ok)), "1");
    check(q.size() == v.line.len() * div, {v.name, " length"},
          d2s(q.size()), d2s(v.line.len() * div));
    misal = 0;
    for (int i = 1; i < q.size(); i++)
      if (q[i] != q[i-1] && (i % div) != 0) misal++;
    check(misal == 0, {v.name, " align"}, d2s(misal), "0");
    s = "";
    for (int b = 0; b < q.size() / div; b++)
      s = {s, sym(q[b*div + div/2], v.ls)};
    check(s == v.line, {v.name, " line"}, s, v.line);
    check(rdy == v.n, {v.name, " ready"}, d2s(rdy), d2s(v.n));
    check(bmis == 0, {v.name, " busy"}, d2s(bmis), "0");
`ifdef SOFTUSB_TX_STUFFCNT_EN
    check(int'(stuff_count) - sc0 == v.stuffs, {v.name, " stuffs"},
          d2s(int'(stuff_count) - sc0), d2s(v.stuffs));
`endif
    repeat (3) @(negedge clk);
  endtask

  logic [3:0] rec[130];
  int cnt, bad;

  initial begin
    vecs[0] = '{"fs_a5", 1'b0, 1, 8'hA5, 8'h00,
                "KJKJKJKKKJJKJJKK00J", 0};
    vecs[1] = '{"fs_ffff", 1'b0, 2, 8'hFF, 8'hFF,
                "KJKJKJKKKKKKKJJJJJJJKKKKKK00J", 2};
    vecs[2] = '{"ls_00", 1'b1, 1, 8'h00, 8'h00,
                "KJKJKJKKJKJKJKJK00J", 0};
    vecs[3] = '{"fs_fc", 1'b0, 1, 8'hFC, 8'h00,
                "KJKJKJKKJKKKKKKKJ00J", 1};

    usb_rst = 1'b1;
    low_speed = 1'b0;
    generate_eop = 1'b0;
    sif.tx_data = 8'h00;
    sif.tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    check(txoe == 1'b0, "rst txoe", d2s(int'(txoe)), "0");
    check({txp, txm} == 2'b10, "rst pins", d2s(int'({txp, txm})), "2");
    check(sif.tx_ready == 1'b0, "rst ready", d2s(int'(sif.tx_ready)), "0");
    check(sif.tx_busy == 1'b0, "rst busy", d2s(int'(sif.tx_busy)), "0");
    usb_rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) run_packet(vecs[i]);

    // standalone LS EOP; tx_valid pulsed during it must not start a packet
    low_speed = 1'b1;
    generate_eop = 1'b1;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      rec[i] = {txoe, txp, txm, sif.tx_ready};
      generate_eop = 1'b0;
      if (i == 10) sif.tx_valid = 1'b1;
      if (i == 60) sif.tx_valid = 1'b0;
    end
    bad = 0;
    for (int i = 0; i < 64; i++) if (rec[i][3:1] != 3'b100) bad++;
    check(bad == 0, "eop se0", d2s(bad), "0");
    bad = 0;
    for (int i = 64; i < 96; i++) if (rec[i][3:1] != 3'b101) bad++;
    check(bad == 0, "eop j", d2s(bad), "0");
    bad = 0;
    for (int i = 96; i < 130; i++) if (rec[i][3]) bad++;
    check(bad == 0, "eop idle", d2s(bad), "0");
    cnt = 0;
    for (int i = 0; i < 130; i++) if (rec[i][0]) cnt++;
    check(cnt == 0, "eop ready", d2s(cnt), "0");

    // EOP and packet requested together: EOP wins, packet follows
    low_speed = 1'b0;
    @(negedge clk);
    generate_eop = 1'b1;
    sif.tx_valid = 1'b1;
    sif.tx_data = 8'hA5;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      rec[i] = {txoe, txp, txm, sif.tx_ready};
      generate_eop = 1'b0;
      if (sif.tx_ready) sif.tx_valid = 1'b0;
    end
    bad = 0;
    for (int i = 0; i < 8; i++) if (rec[i][3:1] != 3'b100) bad++;
    for (int i = 8; i < 12; i++) if (rec[i][3:1] != 3'b110) bad++;
    check(bad == 0, "both eop", d2s(bad), "0");
    check(rec[12][3] == 1'b0, "both gap", d2s(int'(rec[12][3])), "0");
    check(rec[13][3:1] == 3'b101, "both sync k",
          d2s(int'(rec[13][3:1])), "5");
    cnt = 0;
    for (int i = 13; i < 120; i++) if (rec[i][3]) cnt++;
    check(cnt == 76, "both pkt len", d2s(cnt), "76");
    cnt = 0;
    for (int i = 0; i < 120; i++) if (rec[i][0]) cnt++;
    check(cnt == 1, "both ready", d2s(cnt), "1");

    // reset in the middle of DATA
    sif.tx_data = 8'hFF;
    sif.tx_valid = 1'b1;
    repeat (44) @(negedge clk);
    check(txoe == 1'b1, "mid pkt txoe", d2s(int'(txoe)), "1");
    usb_rst = 1'b1;
    sif.tx_valid = 1'b0;
    @(negedge clk);
    usb_rst = 1'b0;
    check(txoe == 1'b0, "abort txoe", d2s(int'(txoe)), "0");
    check(sif.tx_busy == 1'b0, "abort busy", d2s(int'(sif.tx_busy)), "0");
    check({txp, txm} == 2'b10, "abort pins", d2s(int'({txp, txm})), "2");
`ifdef SOFTUSB_TX_STUFFCNT_EN
    check(stuff_count == 16'd0, "abort stuffcnt",
          d2s(int'(stuff_count)), "0");
`endif
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (txoe) cnt++;
    end
    check(cnt == 0, "abort no eop", d2s(cnt), "0");
    run_packet(vecs[1]);
`ifdef SOFTUSB_TX_STUFFCNT_EN
    check(stuff_count == 16'd2, "restart stuffcnt",
          d2s(int'(stuff_count)), "2");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
